// File: rtl/game_tick_scheduler.sv
// Game-loop timebase: shared prescaler, three channel dividers and an idle/run/pause/over sequencer.
// Define MARCH_ACCEL_EN to enable kill-driven speed-up of the invader march period.
module game_tick_scheduler #(
  parameter int BASE_DIV       = 1050000,
  parameter int MARCH_INIT     = 10,
  parameter int MARCH_MIN      = 2,
  parameter int MARCH_STEP     = 1,
  parameter int KILLS_PER_STEP = 4,
  parameter int BULLET_DIV     = 1,
  parameter int SHOT_DIV       = 3
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       kill,
  output logic       base_tick,
  output logic       march_tick,
  output logic       bullet_tick,
  output logic       shot_tick,
  output logic       running,
  output logic [7:0] march_period
);

  localparam int PRE_W = $clog2(BASE_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

  state_t             state, state_next;
  logic [PRE_W-1:0]   prescaler;
  logic [7:0]         march_cnt, bullet_cnt, shot_cnt;
  logic [7:0]         period_q;
  logic               reinit, advance, terminal;

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (game_over) state_next = OVER;
               else if (pause) state_next = PAUSE;
      PAUSE:   if (game_over) state_next = OVER;
               else if (!pause) state_next = RUN;
      OVER:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Only cycles that stay in RUN advance the timebase, so no pulse can land in PAUSE or OVER.
  assign reinit   = (state == IDLE) || ((state == OVER) && start);
  assign advance  = (state == RUN) && !game_over && !pause;
  assign terminal = advance && (prescaler == PRE_W'(BASE_DIV - 1));
  assign running  = (state == RUN);

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      prescaler   <= '0;
      march_cnt   <= '0;
      bullet_cnt  <= '0;
      shot_cnt    <= '0;
      base_tick   <= 1'b0;
      march_tick  <= 1'b0;
      bullet_tick <= 1'b0;
      shot_tick   <= 1'b0;
    end else begin
      base_tick   <= 1'b0;
      march_tick  <= 1'b0;
      bullet_tick <= 1'b0;
      shot_tick   <= 1'b0;
      if (reinit) begin
        prescaler  <= '0;
        march_cnt  <= '0;
        bullet_cnt <= '0;
        shot_cnt   <= '0;
      end else if (terminal) begin
        prescaler <= '0;
        base_tick <= 1'b1;
        // >= rather than == catches a march counter left beyond a freshly shortened period.
        if (march_cnt >= period_q - 8'd1) begin
          march_cnt  <= '0;
          march_tick <= 1'b1;
        end else begin
          march_cnt <= march_cnt + 8'd1;
        end
        if (bullet_cnt >= 8'(BULLET_DIV - 1)) begin
          bullet_cnt  <= '0;
          bullet_tick <= 1'b1;
        end else begin
          bullet_cnt <= bullet_cnt + 8'd1;
        end
        if (shot_cnt >= 8'(SHOT_DIV - 1)) begin
          shot_cnt  <= '0;
          shot_tick <= 1'b1;
        end else begin
          shot_cnt <= shot_cnt + 8'd1;
        end
      end else if (advance) begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

`ifdef MARCH_ACCEL_EN
  localparam int KW = $clog2(KILLS_PER_STEP + 1);

  logic [KW-1:0] kill_cnt;
  logic          kill_ok;
  logic [7:0]    period_dec;

  assign kill_ok    = kill && !game_over && ((state == RUN) || (state == PAUSE));
  assign period_dec = (period_q > 8'(MARCH_MIN + MARCH_STEP)) ? period_q - 8'(MARCH_STEP)
                                                               : 8'(MARCH_MIN);

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      kill_cnt <= '0;
      period_q <= 8'(MARCH_INIT);
    end else if (reinit) begin
      kill_cnt <= '0;
      period_q <= 8'(MARCH_INIT);
    end else if (kill_ok) begin
      if (kill_cnt == KW'(KILLS_PER_STEP - 1)) begin
        kill_cnt <= '0;
        period_q <= period_dec;
      end else begin
        kill_cnt <= kill_cnt + KW'(1);
      end
    end
  end
`else
  logic unused_kill;
  assign unused_kill = kill;
  assign period_q    = 8'(MARCH_INIT);
`endif

  assign march_period = period_q;

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Central timebase and tick scheduler for the game loop.
- One shared prescaler produces a base tick. Three channel dividers derive single-cycle enable pulses from it: invader march, player-bullet motion, and alien-shot motion.
- Game-state sequencing (idle/run/pause/over) gates the shared counter.
- Invader march rate speeds up as aliens are killed. Movement and rendering blocks consume the pulses as clock enables.

Parameters:
- BASE_DIV, 1050000: CLK cycles per base tick (25 ms at 42 MHz); legal ≥2.
- MARCH_INIT, 10: march period in base ticks at game start (250 ms).
- MARCH_MIN, 2: lowest march period allowed; legal 1..MARCH_INIT.
- MARCH_STEP, 1: march-period decrement per speed-up.
- KILLS_PER_STEP, 4: kills needed per speed-up; legal ≥1.
- BULLET_DIV, 1: bullet period in base ticks.
- SHOT_DIV, 3: alien-shot period in base ticks.

Ports:
- CLK  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE/OVER.
- pause  in  1  level; high freezes the timebase.
- game_over  in  1  single-cycle pulse.
- kill  in  1  single-cycle pulse, one per alien destroyed.
- base_tick  out  1  registered pulse.
- march_tick  out  1  registered pulse.
- bullet_tick  out  1  registered pulse.
- shot_tick  out  1  registered pulse.
- running  out  1  high in RUN only.
- march_period  out  8  current march period in base ticks.

Behaviour:
- Reset (Rst=0, async): state IDLE; prescaler, channel counters and kill counter = 0; all ticks = 0; running = 0; march_period = MARCH_INIT.
- State: IDLE.
  - start=1 → RUN.
  - Counters and kill counter are cleared; march_period is reloaded to MARCH_INIT.
- State: RUN.
  - game_over=1 → OVER.
  - Otherwise pause=1 → PAUSE.
  - start is ignored.
- State: PAUSE.
  - game_over=1 → OVER.
  - pause=0 → RUN.
  - Prescaler and channel counters hold their values. No tick is lost or added on resume.
- State: OVER.
  - Counters frozen; all ticks = 0.
  - start=1 → RUN, with the same reinitialisation as IDLE→RUN.
- Priority within one cycle: game_over > pause > kill.
- Prescaler (width = clog2(BASE_DIV)):
  - Counts only in RUN.
  - At count BASE_DIV-1 it wraps to 0 and base_tick=1 on the next cycle.
  - First base_tick occurs BASE_DIV cycles after the first RUN cycle; then exactly every BASE_DIV running cycles.
- Channel counters (8-bit):
  - Advance only on the internal terminal-count cycle.
  - Each channel pulses in the same cycle as base_tick when its counter was at period-1, then wraps to 0.
  - march_tick first fires on base tick #march_period, bullet_tick on #BULLET_DIV, shot_tick on #SHOT_DIV.
  - Coincident pulses are allowed.
- Ticks are always exactly one cycle wide and never asserted outside RUN.
- kill:
  - Counted in RUN and PAUSE; ignored in IDLE and OVER.
  - On the KILLS_PER_STEP-th kill, the kill counter resets and march_period = max(march_period - MARCH_STEP, MARCH_MIN). Saturating, never below MARCH_MIN, never wraps.
  - If the march counter is already ≥ the new period-1, march_tick fires on the next base tick and the counter wraps to 0.
- kill and terminal count in the same cycle: the tick decision uses the old period; the new period applies from the next base tick.
- Reset mid-operation: immediate return to reset values; any pulse in flight is dropped.

Optional Feature:
- Macro: MARCH_ACCEL_EN.
- Defined: kill-driven march speed-up as described above.
- Undefined: kill counter and decrement logic are absent; kill is ignored; march_period is constant at MARCH_INIT.

Test Plan:
- Bench parameters: BASE_DIV=4, MARCH_INIT=3, MARCH_MIN=2, KILLS_PER_STEP=2, BULLET_DIV=1, SHOT_DIV=2.
- Reset check: release Rst, hold start=0 for 20 cycles → all ticks 0, running=0, march_period=3.
- Start and cadence: pulse start → base_tick every 4 cycles starting 4 cycles after RUN entry; bullet_tick with every base_tick; shot_tick every 2nd; march_tick every 3rd (cycles 12, 24, …).
- Pause: assert pause for 10 cycles mid-prescaler → no ticks while paused; the next base_tick arrives after the remaining running cycles (spacing preserved).
- Speed-up: 2 kill pulses → march_period=2 and march_tick every 8 cycles. 4 further kills → march_period stays 2 (saturation).
- Game over: pulse game_over → ticks stop and running=0. Kills ignored. start → march_period=3, first base_tick 4 cycles later.
- Async reset: drive Rst=0 mid-count with a tick due next cycle → outputs clear immediately with no tick. With MARCH_ACCEL_EN undefined, 6 kills → march_period remains 3.
